// File: rtl/mem_op_sequencer_pkg.sv
// rtl/mem_op_sequencer_pkg.sv - shared states and opcode constants for the load/store sequencer
package mem_op_sequencer_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_T0,
      S_T1,
      S_T2,
      S_T3,
      S_T4,
      S_T5,
      S_T6,
      S_T7,
      S_DONE,
      S_FAULT
   } state_e;

   localparam int OPW_C = 5;

   localparam logic [OPW_C-1:0] OP_LD_C  = 5'b00000;
   localparam logic [OPW_C-1:0] OP_LDI_C = 5'b00001;
   localparam logic [OPW_C-1:0] OP_ST_C  = 5'b00010;

   localparam logic [OPW_C-1:0] ALU_NOP_C = 5'b00000;
   localparam logic [OPW_C-1:0] ALU_ADD_C = 5'b00001;
   localparam logic [OPW_C-1:0] ALU_SUB_C = 5'b00010;
   localparam logic [OPW_C-1:0] ALU_AND_C = 5'b00011;
   localparam logic [OPW_C-1:0] ALU_OR_C  = 5'b00100;
   localparam logic [OPW_C-1:0] ALU_SHR_C = 5'b00101;
   localparam logic [OPW_C-1:0] ALU_SHL_C = 5'b00110;
   localparam logic [OPW_C-1:0] ALU_ROR_C = 5'b00111;
   localparam logic [OPW_C-1:0] ALU_ROL_C = 5'b01000;
   localparam logic [OPW_C-1:0] ALU_MUL_C = 5'b01001;
   localparam logic [OPW_C-1:0] ALU_DIV_C = 5'b01010;
   localparam logic [OPW_C-1:0] ALU_NEG_C = 5'b01011;
   localparam logic [OPW_C-1:0] ALU_NOT_C = 5'b01100;

endpackage

// File: rtl/mem_op_sequencer_mem_wait_timer.sv
// rtl/mem_op_sequencer_mem_wait_timer.sv - counts memory wait cycles and flags timeout
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 8
) (
   input  logic clk_i,
   input  logic clr_i,
   input  logic clear_i,
   input  logic wait_i,
   output logic first_o,
   output logic expire_o
);

   localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (wait_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The cycle that would be the MEM_TIMEOUT-th consecutive wait expires.
   assign expire_o = (MEM_TIMEOUT != 0) && wait_i && (cnt_q == LAST);
   assign first_o  = (cnt_q == '0);

endmodule

// File: rtl/mem_op_sequencer.sv
// rtl/mem_op_sequencer.sv - Moore FSM driving datapath strobes for ld, ldi and st
module mem_op_sequencer
   import mem_op_sequencer_pkg::*;
#(
   parameter int               OPW         = 5,
   parameter logic [OPW-1:0]   ALU_ADD     = OPW'(ALU_ADD_C),
   parameter logic [OPW-1:0]   OP_LD       = OPW'(OP_LD_C),
   parameter logic [OPW-1:0]   OP_LDI      = OPW'(OP_LDI_C),
   parameter logic [OPW-1:0]   OP_ST       = OPW'(OP_ST_C),
   parameter int               MEM_TIMEOUT = 8
) (
   input  logic           clk,
   input  logic           clr,
   input  logic           start,
   input  logic [OPW-1:0] ir_op,
   input  logic           mem_ready,
   output logic           PCout,
   output logic           MARin,
   output logic           Zin,
   output logic           incPC,
   output logic           ZLowOut,
   output logic           PCin,
   output logic           read,
   output logic           MDRin,
   output logic           MDRout,
   output logic           IRin,
   output logic           Grb,
   output logic           BAout,
   output logic           Yin,
   output logic           Cout,
   output logic           Gra,
   output logic           Rin,
   output logic           Rout,
   output logic           write,
   output logic [OPW-1:0] alu_op,
   output logic           busy,
   output logic           done,
   output logic           fault
);

   state_e         state_q, state_d;
   logic [OPW-1:0] op_q, op_d;
   logic           in_mem, mem_ok, wait_cyc, first_cyc, expire;

   assign in_mem = (state_q == S_T1)
                 || ((state_q == S_T6) && (op_q == OP_LD))
                 || ((state_q == S_T7) && (op_q == OP_ST));
   assign mem_ok   = (MEM_TIMEOUT == 0) || mem_ready;
   assign wait_cyc = in_mem && !mem_ok;

   mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_timer (
      .clk_i   (clk),
      .clr_i   (clr),
      .clear_i (!in_mem),
      .wait_i  (wait_cyc),
      .first_o (first_cyc),
      .expire_o(expire)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= S_IDLE;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_T0;
         S_T0:    state_d = S_T1;
         S_T1: begin
            if (mem_ok)      state_d = S_T2;
            else if (expire) state_d = S_FAULT;
         end
         S_T2:    state_d = S_T3;
         S_T3: begin
            op_d = ir_op;
            if ((ir_op == OP_LD) || (ir_op == OP_LDI) || (ir_op == OP_ST)) state_d = S_T4;
            else                                                           state_d = S_FAULT;
         end
         S_T4:    state_d = S_T5;
         S_T5:    state_d = (op_q == OP_LDI) ? S_DONE : S_T6;
         S_T6: begin
            if (!in_mem || mem_ok) state_d = S_T7;
            else if (expire)       state_d = S_FAULT;
         end
         S_T7: begin
            if (!in_mem || mem_ok) state_d = S_DONE;
            else if (expire)       state_d = S_FAULT;
         end
         S_DONE:  state_d = S_IDLE;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      PCout   = 1'b0;
      MARin   = 1'b0;
      Zin     = 1'b0;
      incPC   = 1'b0;
      ZLowOut = 1'b0;
      PCin    = 1'b0;
      read    = 1'b0;
      MDRin   = 1'b0;
      MDRout  = 1'b0;
      IRin    = 1'b0;
      Grb     = 1'b0;
      BAout   = 1'b0;
      Yin     = 1'b0;
      Cout    = 1'b0;
      Gra     = 1'b0;
      Rin     = 1'b0;
      Rout    = 1'b0;
      write   = 1'b0;
      alu_op  = '0;
      busy    = (state_q != S_IDLE) && (state_q != S_FAULT);
      done    = (state_q == S_DONE);
      fault   = (state_q == S_FAULT);
      case (state_q)
         S_T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            incPC = 1'b1;
            Zin   = 1'b1;
         end
         S_T1: begin
            ZLowOut = 1'b1;
            PCin    = first_cyc;
            read    = 1'b1;
            MDRin   = 1'b1;
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T3: begin
            Grb   = 1'b1;
            BAout = 1'b1;
            Yin   = 1'b1;
         end
         S_T4: begin
            Cout   = 1'b1;
            Zin    = 1'b1;
            alu_op = ALU_ADD;
         end
         S_T5: begin
            ZLowOut = 1'b1;
            if (op_q == OP_LDI) begin
               Gra = 1'b1;
               Rin = 1'b1;
            end else begin
               MARin = 1'b1;
            end
         end
         S_T6: begin
            MDRin = 1'b1;
            if (op_q == OP_ST) begin
               Gra  = 1'b1;
               Rout = 1'b1;
            end else begin
               read = 1'b1;
            end
         end
         S_T7: begin
            if (op_q == OP_ST) begin
               write = 1'b1;
            end else begin
               MDRout = 1'b1;
               Gra    = 1'b1;
               Rin    = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: doc/mem_op_sequencer.md
Name: mem_op_sequencer

Overview:
- Moore control FSM that generates the bus/register control strobes for the load/store class of instructions: ld, ldi and st.
- Sits between the IR and the existing datapath control inputs, replacing hand-driven T-state stimulus.
- Generalised over ALU opcode width, instruction opcodes and memory wait-state tolerance.
- Adds a memory ready handshake, a timeout and an illegal-opcode fault.

Parameters:
OPW, 5, width of instruction opcode and ALU opcode fields
ALU_ADD, 5'b00001, ALU opcode driven during address add
OP_LD, 5'b00000, instruction opcode for ld
OP_LDI, 5'b00001, instruction opcode for ldi
OP_ST, 5'b00010, instruction opcode for st
MEM_TIMEOUT, 8, max cycles waiting on mem_ready before fault; 0 = memory assumed single-cycle, mem_ready ignored

Ports:
clk  in  1  system clock, rising edge
clr  in  1  synchronous active-high reset
start  in  1  begin fetch/execute of one instruction (sampled in IDLE only)
ir_op  in  OPW  IR[31:27] from datapath IR
mem_ready  in  1  memory read/write completes this cycle
PCout, MARin, Zin, incPC, ZLowOut, PCin, read, MDRin, MDRout, IRin, Grb, BAout, Yin, Cout, Gra, Rin, Rout, write  out  1 each  datapath strobes
alu_op  out  OPW  ALU opcode (0 = nop)
busy  out  1  high in any state except IDLE/FAULT
done  out  1  one-cycle pulse, instruction retired
fault  out  1  sticky; illegal opcode or memory timeout

Behaviour:
- Reset (clr=1 at posedge): state=IDLE, wait counter=0, latched op=0. All outputs 0 and alu_op=0 in IDLE. clr mid-instruction aborts immediately; no strobes on the following cycle.
- Outputs are a pure decode of the state register (Moore). No strobe is asserted outside its listed state.
- IDLE:
  - start=1 -> T0 next cycle.
  - start while busy or in FAULT is ignored.
- T0: PCout, MARin, incPC, Zin -> T1.
- T1: ZLowOut, PCin, read, MDRin.
  - Stay while mem_ready=0 (PCin asserted only on the first T1 cycle).
  - Exit to T2 when mem_ready=1.
- T2: MDRout, IRin -> T3.
- T3: Grb, BAout, Yin; latch ir_op into op_q on exit.
  - If op_q is not LD, LDI or ST -> FAULT instead of T4.
- T4: Cout, Zin, alu_op=ALU_ADD -> T5.
- ldi:
  - T5: ZLowOut, Gra, Rin -> DONE.
- ld:
  - T5: ZLowOut, MARin -> T6.
  - T6: read, MDRin (wait on mem_ready as in T1) -> T7.
  - T7: MDRout, Gra, Rin -> DONE.
- st:
  - T5: ZLowOut, MARin -> T6.
  - T6: Gra, Rout, MDRin -> T7.
  - T7: write (hold until mem_ready) -> DONE.
- DONE: done=1 for one cycle -> IDLE. Back-to-back instructions require start again in IDLE.
- Wait counter:
  - Cleared on entry to each memory state (T1, ld-T6, st-T7); increments each cycle mem_ready=0.
  - Reaching MEM_TIMEOUT while still waiting -> FAULT.
  - MEM_TIMEOUT=0: memory states last exactly 1 cycle.
- FAULT: all strobes 0, fault=1, busy=0. Leave only via clr.
- Latency with mem_ready tied high:
  - ldi = start + 6 state cycles (T0..T5) + DONE.
  - ld/st = start + 8 state cycles (T0..T7) + DONE.
- mem_ready=1 together with the timeout cycle: the ready wins and the FSM advances.

Decomposition:
- Shared package: state enumeration (IDLE, T0..T7, DONE, FAULT), instruction opcode constants, ALU opcode constants (nop..not, add=5'b00001).
- One sub-module is natural: mem_wait_timer (counter, clear, expiry flag, MEM_TIMEOUT parameter).
- Output decode stays in the top module.

Test Plan:
- ldi R0,$45(R1), IR=0x08080045, ir_op=00001, mem_ready=1 -> strobes T0..T5 exactly as listed; alu_op=00001 in T4 only; done at cycle 7 after start; datapath R0=0x4A.
- ld R2,$4A(R0), R0=0, mem[0x4A]=60, ir_op=00000, mem_ready high after 3 cycles in T1 and T6 -> T1/T6 held 3 cycles; done; R2=60.
- st $4A(R0),R3, R3=0x1234, ir_op=00010 -> Rout+MDRin in T6, write in T7; mem[0x4A]=0x1234; no Rin pulse during the instruction.
- mem_ready stuck 0, MEM_TIMEOUT=8 -> FAULT exactly 8 cycles after T1 entry; fault=1, all strobes 0; start ignored; clr returns to IDLE.
- ir_op=00111 -> FAULT on exit from T3; Zin never asserted with alu_op=ADD.
- clr asserted during T4 of ld -> IDLE next cycle, all outputs 0; a fresh start runs a clean T0.
